// File: rtl/fb_vport_gen.sv
// fb_vport_gen: buffers an RGB555 start/dv/ready pixel stream and replays it against free-running
// raster timing as 8-bit RGB/HS/VS/DE. Define FB_TEST_PATTERN_EN to add the iPATTERN colour-bar override.
module fb_vport_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int FIFO_AW  = 4
) (
   input  logic        iCLK,
   input  logic        iRESET,
   input  logic [14:0] iST_DATA,
   input  logic        iST_START,
   input  logic        iST_DV,
`ifdef FB_TEST_PATTERN_EN
   input  logic        iPATTERN,
`endif
   output logic        oST_READY,
   output logic [7:0]  oRED,
   output logic [7:0]  oGRN,
   output logic [7:0]  oBLU,
   output logic        oHS,
   output logic        oVS,
   output logic        oDE,
   output logic        oLOCKED,
   output logic        oUNDERRUN,
   output logic        oDESYNC
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int DEPTH   = 1 << FIFO_AW;
   localparam int CW      = FIFO_AW + 1;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   typedef enum logic [1:0] {HUNT, FILL, RUN} vpState_t;

   typedef struct packed {
      logic        start;
      logic [14:0] data;
   } fifoWord_t;

   function automatic logic [7:0] expand(input logic [4:0] c5);
      return {c5, c5[4:2]};
   endfunction

   // ---------------- raster timing ----------------
   logic [HW-1:0] hCnt;
   logic [VW-1:0] vCnt;
   logic          hWrap, frameEnd, origin, active, hsWin, vsWin;

   assign hWrap    = (hCnt == H_LAST);
   assign frameEnd = hWrap && (vCnt == V_LAST);
   assign origin   = (hCnt == '0) && (vCnt == '0);
   assign active   = (hCnt < H_ACT) && (vCnt < V_ACT);
   assign hsWin    = (hCnt >= HS_BEG) && (hCnt < HS_END);
   assign vsWin    = (vCnt >= VS_BEG) && (vCnt < VS_END);

   // Counters never stall: errors only affect the stream side.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         hCnt <= '0;
         vCnt <= '0;
      end else begin
         hCnt <= hWrap ? '0 : hCnt + HW'(1);
         if (hWrap)
            vCnt <= (vCnt == V_LAST) ? '0 : vCnt + VW'(1);
      end
   end

   // ---------------- pixel FIFO ----------------
   fifoWord_t          mem [DEPTH];
   fifoWord_t          head;
   logic [FIFO_AW-1:0] wrPtr, rdPtr;
   logic [CW-1:0]      count;
   logic               empty, full;

   assign head  = mem[rdPtr];
   assign empty = (count == '0);
   assign full  = (count == CNT_FULL);

   // ---------------- stream control ----------------
   vpState_t state, nextState;
   logic     rdyEn, stReady, xfer, popDue, underrun, desync, flush, pop, wr;

   // rdyEn holds ready low for the first cycle out of reset.
   assign stReady  = rdyEn && ((state == HUNT) || !full);
   assign xfer     = iST_DV && stReady;
   assign popDue   = (state == RUN) && active;
   assign underrun = popDue && empty;
   assign desync   = popDue && !empty && (head.start != origin);
   assign flush    = underrun || desync;
   assign pop      = popDue && !empty && !desync;
   assign wr       = xfer && !flush && ((state != HUNT) || iST_START);

   assign oST_READY = stReady;
   assign oLOCKED   = (state == RUN);

   always_ff @(posedge iCLK) begin
      if (wr)
         mem[wrPtr] <= fifoWord_t'({iST_START, iST_DATA});
   end

   always_ff @(posedge iCLK) begin
      if (iRESET || flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (wr)
            wrPtr <= wrPtr + FIFO_AW'(1);
         if (pop)
            rdPtr <= rdPtr + FIFO_AW'(1);
         if (wr && !pop)
            count <= count + CW'(1);
         else if (pop && !wr)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         state <= HUNT;
         rdyEn <= 1'b0;
      end else begin
         state <= nextState;
         rdyEn <= 1'b1;
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         HUNT:    if (xfer && iST_START) nextState = FILL;
         FILL:    if (frameEnd)          nextState = RUN;
         RUN:     if (flush)             nextState = HUNT;
         default:                        nextState = HUNT;
      endcase
   end

   // ---------------- pixel colour ----------------
   logic [7:0] redNxt, grnNxt, bluNxt;

`ifdef FB_TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;
   logic [HW-1:0] barQuot;
   logic [2:0]    barIdx;
   logic [2:0]    barRgb;

   assign barQuot = hCnt / HW'(BAR_W);
   assign barIdx  = barQuot[2:0];

   // {R,G,B} on/off per bar, left to right.
   always_comb begin
      barRgb = 3'b000;
      unique case (barIdx)
         3'd0: barRgb = 3'b111;
         3'd1: barRgb = 3'b110;
         3'd2: barRgb = 3'b011;
         3'd3: barRgb = 3'b010;
         3'd4: barRgb = 3'b101;
         3'd5: barRgb = 3'b100;
         3'd6: barRgb = 3'b001;
         default: barRgb = 3'b000;
      endcase
   end
`endif

   always_comb begin
      redNxt = '0;
      grnNxt = '0;
      bluNxt = '0;
      if (pop) begin
         redNxt = expand(head.data[14:10]);
         grnNxt = expand(head.data[9:5]);
         bluNxt = expand(head.data[4:0]);
      end
`ifdef FB_TEST_PATTERN_EN
      if (iPATTERN && active) begin
         redNxt = {8{barRgb[2]}};
         grnNxt = {8{barRgb[1]}};
         bluNxt = {8{barRgb[0]}};
      end
`endif
   end

   // ---------------- registered video outputs ----------------
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         oDE       <= 1'b0;
         oHS       <= !HS_POL;
         oVS       <= !VS_POL;
         oRED      <= '0;
         oGRN      <= '0;
         oBLU      <= '0;
         oUNDERRUN <= 1'b0;
         oDESYNC   <= 1'b0;
      end else begin
         oDE       <= active;
         oHS       <= hsWin ? HS_POL : !HS_POL;
         oVS       <= vsWin ? VS_POL : !VS_POL;
         oRED      <= redNxt;
         oGRN      <= grnNxt;
         oBLU      <= bluNxt;
         oUNDERRUN <= underrun;
         oDESYNC   <= desync && !underrun;
      end
   end

endmodule

// File: tb/tb_fb_vport_gen.sv
// tb_fb_vport_gen: randomized stream against a queue-based frame model of the video port.
module tb_fb_vport_gen;

   localparam int HA = 8, HF = 2, HSY = 2, HB = 2;
   localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
   localparam int AW    = 3;
   localparam int HT    = HA + HF + HSY + HB;
   localparam int VT    = VA + VF + VSY + VB;
   localparam int DEPTH = 1 << AW;
   localparam int FRAME = HA * VA;
   localparam int NCYC  = 3800;
   localparam int M_HUNT = 0, M_FILL = 1, M_RUN = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [14:0] dat;
   logic        st, dv;
   logic        oST_READY, oHS, oVS, oDE, oLOCKED, oUNDERRUN, oDESYNC;
   logic [7:0]  oRED, oGRN, oBLU;

   always #5 clk = ~clk;

   fb_vport_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .FIFO_AW(AW)
   ) dut (
      .iCLK      (clk),
      .iRESET    (rst),
      .iST_DATA  (dat),
      .iST_START (st),
      .iST_DV    (dv),
`ifdef FB_TEST_PATTERN_EN
      .iPATTERN  (1'b0),
`endif
      .oST_READY (oST_READY),
      .oRED      (oRED),
      .oGRN      (oGRN),
      .oBLU      (oBLU),
      .oHS       (oHS),
      .oVS       (oVS),
      .oDE       (oDE),
      .oLOCKED   (oLOCKED),
      .oUNDERRUN (oUNDERRUN),
      .oDESYNC   (oDESYNC)
   );

   int checks = 0, failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Model: raster position as a single frame-relative index, FIFO as a queue.
   int          pos = 0;
   int          mode = M_HUNT;
   logic [15:0] q[$];
   bit          rstGate = 1'b1;
   bit          mXfer;
   bit          eDe, eHs, eVs, eUr, eDs;
   logic [7:0]  eR, eG, eB;

   function automatic int expand5(input int x);
      int c = x & 31;
      return (c << 3) | (c >> 2);
   endfunction

   function automatic bit modelReady();
      return !rstGate && (mode == M_HUNT || q.size() < DEPTH);
   endfunction

   task automatic modelStep();
      int h, v, w, m0;
      bit act, err;
      if (rst) begin
         pos = 0; mode = M_HUNT; q.delete(); rstGate = 1'b1;
         eDe = 0; eHs = 1; eVs = 1; eUr = 0; eDs = 0;
         eR = '0; eG = '0; eB = '0;
         return;
      end
      h   = pos % HT;
      v   = pos / HT;
      act = (h < HA) && (v < VA);
      m0  = mode;
      eDe = act;
      eHs = !(h >= HA + HF && h < HA + HF + HSY);
      eVs = !(v >= VA + VF && v < VA + VF + VSY);
      eR = '0; eG = '0; eB = '0; eUr = 0; eDs = 0; err = 0;
      if (m0 == M_RUN && act) begin
         if (q.size() == 0) begin
            eUr = 1; err = 1;
         end else if (q[0][15] != (pos == 0)) begin
            eDs = 1; err = 1;
         end else begin
            w  = int'(q.pop_front());
            eR = 8'(expand5(w >> 10));
            eG = 8'(expand5(w >> 5));
            eB = 8'(expand5(w));
         end
      end
      if (err) begin
         q.delete();
         mode = M_HUNT;
      end else begin
         if (mXfer && (m0 != M_HUNT || st)) q.push_back({st, dat});
         if (m0 == M_HUNT && mXfer && st) mode = M_FILL;
         if (m0 == M_FILL && pos == HT * VT - 1) mode = M_RUN;
      end
      pos = (pos + 1) % (HT * VT);
      rstGate = 1'b0;
   endtask

   // Source state: walks frame word index srcIdx, start on index 0.
   int srcIdx = 0, garbage = 0, stopAt = -1, badIdx = -1, dvProb = 100, dataMode = 0;
   int urCnt = 0, dsCnt = 0;
   bit srcEn = 0, stopped = 0, armStop = 0, armBad = 0, randMode = 0, sawLock = 0, didMidReset = 0;

   initial begin
      rst = 1'b1; dv = 1'b0; st = 1'b0; dat = '0;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         if (cyc >= 1) begin
            chk("de",   32'(oDE),       32'(eDe));
            chk("hs",   32'(oHS),       32'(eHs));
            chk("vs",   32'(oVS),       32'(eVs));
            chk("rgb",  {8'h0, oRED, oGRN, oBLU}, {8'h0, eR, eG, eB});
            chk("urun", 32'(oUNDERRUN), 32'(eUr));
            chk("dsyn", 32'(oDESYNC),   32'(eDs));
            chk("lock", 32'(oLOCKED),   32'(mode == M_RUN));
            chk("rdy",  32'(oST_READY), 32'(modelReady()));
            if (cyc >= 200 && cyc < 950 && oLOCKED) sawLock = 1;
            if (cyc >= 950 && cyc < 1350 && oUNDERRUN) urCnt++;
            if (cyc >= 1350 && cyc < 1750 && oDESYNC) dsCnt++;
         end

         case (cyc)
            200:  begin srcEn = 1; garbage = 2; dataMode = 0; end
            650:  dataMode = 1;
            950:  begin dataMode = 2; armStop = 1; end
            1250: begin stopped = 0; stopAt = -1; srcIdx = 0; end
            1350: armBad = 1;
            default: ;
         endcase
         if (cyc >= 1900 && cyc % 100 == 0) begin
            randMode = 1; dataMode = 2;
            dvProb = int'($urandom_range(100, 60));
         end

         rst = (cyc == 0);
         if (!didMidReset && cyc >= 1800 && (pos % HT) == 4) begin
            rst = 1'b1; didMidReset = 1;
         end
         if (randMode && $urandom_range(599) == 0) rst = 1'b1;

         if (garbage > 0) begin
            dv = 1'b1; st = 1'b0; dat = 15'($urandom);
         end else if (!srcEn || stopped) begin
            dv = 1'b0; st = 1'b0; dat = '0;
         end else begin
            dv  = (int'($urandom_range(99)) < dvProb);
            st  = (srcIdx == 0) || (srcIdx == badIdx);
            if (randMode && $urandom_range(99) < 2) st = !st;
            dat = (dataMode == 0) ? 15'h7C00 : (dataMode == 1) ? 15'h0421 : 15'($urandom);
         end

         mXfer = !rst && dv && modelReady();
         modelStep();

         if (mXfer) begin
            if (garbage > 0) garbage--;
            else begin
               srcIdx = (srcIdx + 1) % FRAME;
               if (srcIdx == 0) begin
                  badIdx = armBad ? 4 : -1;
                  armBad = 0;
                  if (armStop) begin stopAt = 10; armStop = 0; end
               end
               if (srcIdx == stopAt) stopped = 1;
            end
         end
      end
      chk("sawLock", 32'(sawLock), 32'd1);
      chk("urCnt",   32'(urCnt),   32'd1);
      chk("dsCnt",   32'(dsCnt),   32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fb_vport_gen.md
Name: fb_vport_gen

Overview:
- Video port stage between the framebuffer pixel stream and the DVI/TMDS output.
- Consumes the start/dv/ready pixel stream carrying RGB555 words plus a frame-start flag, and buffers it in a small FIFO.
- Generates raster timing and drives 8-bit RGB, HS, VS and DE to the DVI output block.
- Detects underrun and frame misalignment, then resynchronises to the next frame start without software help.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, HS pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, VS pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, HS active level
VS_POL, 0, VS active level
FIFO_AW, 4, FIFO address width (depth 2**FIFO_AW)

Ports:
iCLK  in  1  pixel clock (video clock domain)
iRESET  in  1  synchronous reset, active-high
iST_DATA  in  15  pixel {R[4:0],G[4:0],B[4:0]}
iST_START  in  1  word is first pixel of a frame
iST_DV  in  1  word valid
oST_READY  out  1  sink can accept the word; transfer occurs when iST_DV & oST_READY
oRED  out  8  red
oGRN  out  8  green
oBLU  out  8  blue
oHS  out  1  horizontal sync
oVS  out  1  vertical sync
oDE  out  1  data enable
oLOCKED  out  1  state is RUN
oUNDERRUN  out  1  one-cycle pulse: FIFO empty while a pixel is due
oDESYNC  out  1  one-cycle pulse: start flag mismatch at pop

Behaviour:
- Clocking and reset: single clock iCLK; iRESET is synchronous, active-high.
- Reset values:
  - hcnt = vcnt = 0; FIFO empty; state HUNT.
  - oDE = 0, oHS = !HS_POL, oVS = !VS_POL, RGB = 0.
  - oST_READY = 0, oLOCKED = 0, pulse outputs = 0.
- Totals: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
- Horizontal counter: hcnt increments every cycle and wraps at H_TOTAL-1.
- Vertical counter: vcnt increments when hcnt wraps and itself wraps at V_TOTAL-1. Counters free-run in every state.
- Active region: active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- Sync windows:
  - HS is active for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - VS is active for the analogous vcnt window, on whole lines.
- Output latency: all video outputs are registered, one cycle after the counter values that produce them. RGB is aligned with oDE.
- Colour expansion: c8 = {c5, c5[4:2]} per channel. When not popping valid data during active, RGB = 0.
- FIFO:
  - Width 16 ({start, data}); first-word fall-through head.
  - Write and pop in the same cycle are allowed, with count unchanged.
  - oST_READY = !full in FILL/RUN; 1 in HUNT.
- State HUNT:
  - Transfers are discarded unless iST_START = 1.
  - A start word is written to the FIFO, then go to FILL.
- State FILL:
  - Accept words; no pops; display black.
  - At hcnt = H_TOTAL-1 && vcnt = V_TOTAL-1, go to RUN. The next cycle is pixel (0,0).
- State RUN (oLOCKED = 1):
  - Pop one word every cycle where active = 1.
  - At (0,0) the head must have start = 1. At any other active position the head must have start = 0. A violation pulses oDESYNC.
  - If active and the FIFO is empty, pulse oUNDERRUN and output black for that pixel.
- Error recovery: on either error, flush the FIFO the same cycle and go to HUNT. An incoming word in the error cycle is dropped. Timing continues uninterrupted.
- Simultaneous events: if underrun and desync would coincide, oUNDERRUN takes priority and only one pulse is asserted.
- Reset mid-frame: everything returns to reset values next cycle; the stream is re-hunted.

Optional Feature:
- FB_TEST_PATTERN_EN defined:
  - Adds input iPATTERN (1 bit).
  - When iPATTERN = 1, RGB during active shows 8 vertical colour bars of width H_ACTIVE/8: white, yellow, cyan, green, magenta, red, blue, black (channels 8'hFF/8'h00).
  - FIFO pops and error checks proceed unchanged.
- Undefined: port absent, no bar logic synthesised.

Test Plan (bench parameters H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, FIFO_AW=3, polarities 0):
- Timing after reset: oHS low exactly for hcnt 10..11. oVS low for line 5. oDE high 8 cycles per line on lines 0..3. Each output appears 1 cycle after its counter value.
- Lock:
  - Stimulus: stream of 2 garbage words (start=0), then a frame of 32 words, first with start=1, data 15'h7C00 (red).
  - Response: garbage dropped; oLOCKED rises at frame end; first active pixel RGB = FF/00/00.
- Expansion: data 15'h0421 -> RGB = 08/08/08.
- Underrun:
  - Stimulus: in RUN, stop iST_DV after 10 words.
  - Response: oUNDERRUN pulses once on the 11th active pixel; RGB 0; oLOCKED falls; HUNT then relocks on the next start.
- Desync:
  - Stimulus: start=1 on the 5th word of a frame.
  - Response: oDESYNC pulse at that pop; FIFO flushed; oST_READY = 1 the next cycle.
- Backpressure and reset:
  - Stimulus: hold iST_DV = 1 in FILL.
  - Response: oST_READY drops after 8 writes.
  - Stimulus: assert iRESET mid-line.
  - Response: next cycle all outputs at reset values, oHS = 1.
